// File: rtl/icache_dataram_arb.sv
// rtl/icache_dataram_arb.sv - single-port icache data RAM arbiter for hit reads and linefill writes
//
// Purpose: shares one single-port data RAM between hit-read bursts and
// linefill write bursts. A burst occupies the RAM for a whole line
// (BEAT_NUM beats). Linefills win ties until a waiting read has been
// passed over STARVE_MAX times.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   dataram_rd_*                     hit-read request (vld/rdy, way, index)
//   linefill_*                       per-beat linefill write (vld/rdy, way,
//                                    index, mshr idx, beat data)
//   ram_en/we/way/addr/wdata/rdata   data RAM port, read data one cycle later
//   upstream_txdat_en/last/data      read beats returned upstream
//   linefill_done/linefill_done_idx  one-cycle pulse once a full line is written
module icache_dataram_arb #(
  parameter int INDEX_W     = 7,
  parameter int BEAT_NUM    = 4,
  parameter int BEAT_DATA_W = 256,
  parameter int MSHR_IDX_W  = 3,
  parameter int STARVE_MAX  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 dataram_rd_vld,
  output logic                                 dataram_rd_rdy,
  input  logic                                 dataram_rd_way,
  input  logic [INDEX_W-1:0]                   dataram_rd_index,
  input  logic                                 linefill_beat_vld,
  output logic                                 linefill_beat_rdy,
  input  logic                                 linefill_way,
  input  logic [INDEX_W-1:0]                   linefill_index,
  input  logic [MSHR_IDX_W-1:0]                linefill_mshr_idx,
  input  logic [BEAT_DATA_W-1:0]               linefill_beat_data,
  output logic                                 ram_en,
  output logic                                 ram_we,
  output logic                                 ram_way,
  output logic [INDEX_W+$clog2(BEAT_NUM)-1:0]  ram_addr,
  output logic [BEAT_DATA_W-1:0]               ram_wdata,
  input  logic [BEAT_DATA_W-1:0]               ram_rdata,
  output logic                                 upstream_txdat_en,
  output logic                                 upstream_txdat_last,
  output logic [BEAT_DATA_W-1:0]               upstream_txdat_data,
  output logic                                 linefill_done,
  output logic [MSHR_IDX_W-1:0]                linefill_done_idx
);

  localparam int BEAT_W   = $clog2(BEAT_NUM);
  localparam int ADDR_W   = INDEX_W + BEAT_W;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  localparam logic [BEAT_W-1:0]   BEAT_ZERO  = '0;
  localparam logic [BEAT_W-1:0]   BEAT_ONE   = BEAT_W'(1);
  localparam logic [BEAT_W-1:0]   BEAT_LAST  = BEAT_W'(BEAT_NUM - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_BURST = 2'd1,
    S_WR_BURST = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [STARVE_W-1:0]     starve_q, starve_d;
  logic                    rd_way_q, rd_way_d;
  logic [INDEX_W-1:0]      rd_index_q, rd_index_d;
  logic                    lf_way_q, lf_way_d;
  logic [INDEX_W-1:0]      lf_index_q, lf_index_d;
  logic [MSHR_IDX_W-1:0]   lf_mshr_q, lf_mshr_d;
  logic                    done_q, done_d;
  logic [MSHR_IDX_W-1:0]   done_idx_q, done_idx_d;
  logic                    tx_en_q, tx_en_d;
  logic                    tx_last_q, tx_last_d;
  logic                    hold_way_q, hold_way_d;
  logic [ADDR_W-1:0]       hold_addr_q, hold_addr_d;
  logic [BEAT_DATA_W-1:0]  hold_wdata_q, hold_wdata_d;

  // Arbitration, only meaningful in IDLE.
  logic rd_win, lf_win;
  // RAM access issued this cycle.
  logic                    acc_en, acc_we, acc_way, acc_last;
  logic [ADDR_W-1:0]       acc_addr;
  logic [BEAT_DATA_W-1:0]  acc_wdata;

  always_comb begin
    rd_win = dataram_rd_vld && (!linefill_beat_vld || (starve_q == STARVE_LIM));
    lf_win = linefill_beat_vld && !rd_win;
  end

  // State register and all other flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      starve_q     <= '0;
      rd_way_q     <= 1'b0;
      rd_index_q   <= '0;
      lf_way_q     <= 1'b0;
      lf_index_q   <= '0;
      lf_mshr_q    <= '0;
      done_q       <= 1'b0;
      done_idx_q   <= '0;
      tx_en_q      <= 1'b0;
      tx_last_q    <= 1'b0;
      hold_way_q   <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      starve_q     <= starve_d;
      rd_way_q     <= rd_way_d;
      rd_index_q   <= rd_index_d;
      lf_way_q     <= lf_way_d;
      lf_index_q   <= lf_index_d;
      lf_mshr_q    <= lf_mshr_d;
      done_q       <= done_d;
      done_idx_q   <= done_idx_d;
      tx_en_q      <= tx_en_d;
      tx_last_q    <= tx_last_d;
      hold_way_q   <= hold_way_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
    end
  end

  // RAM access for the current cycle. Beat 0 comes straight from the
  // requester's inputs in the grant cycle; later beats use latched targets.
  always_comb begin
    acc_en    = 1'b0;
    acc_we    = 1'b0;
    acc_last  = 1'b0;
    acc_way   = hold_way_q;
    acc_addr  = hold_addr_q;
    acc_wdata = hold_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (rd_win) begin
          acc_en   = 1'b1;
          acc_way  = dataram_rd_way;
          acc_addr = {dataram_rd_index, BEAT_ZERO};
        end else if (lf_win) begin
          acc_en    = 1'b1;
          acc_we    = 1'b1;
          acc_way   = linefill_way;
          acc_addr  = {linefill_index, BEAT_ZERO};
          acc_wdata = linefill_beat_data;
        end
      end
      S_RD_BURST: begin
        acc_en   = 1'b1;
        acc_way  = rd_way_q;
        acc_addr = {rd_index_q, beat_q};
        acc_last = (beat_q == BEAT_LAST);
      end
      S_WR_BURST: begin
        if (linefill_beat_vld) begin
          acc_en    = 1'b1;
          acc_we    = 1'b1;
          acc_way   = lf_way_q;
          acc_addr  = {lf_index_q, beat_q};
          acc_wdata = linefill_beat_data;
          acc_last  = (beat_q == BEAT_LAST);
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      acc_en = 1'b0;
      acc_we = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    starve_d     = starve_q;
    rd_way_d     = rd_way_q;
    rd_index_d   = rd_index_q;
    lf_way_d     = lf_way_q;
    lf_index_d   = lf_index_q;
    lf_mshr_d    = lf_mshr_q;
    done_d       = 1'b0;
    done_idx_d   = done_idx_q;
    tx_en_d      = acc_en && !acc_we;
    tx_last_d    = acc_en && !acc_we && acc_last;
    hold_way_d   = acc_en ? acc_way   : hold_way_q;
    hold_addr_d  = acc_en ? acc_addr  : hold_addr_q;
    hold_wdata_d = acc_en ? acc_wdata : hold_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (rd_win) begin
          state_d    = S_RD_BURST;
          beat_d     = BEAT_ONE;
          starve_d   = '0;
          rd_way_d   = dataram_rd_way;
          rd_index_d = dataram_rd_index;
        end else if (lf_win) begin
          state_d    = S_WR_BURST;
          beat_d     = BEAT_ONE;
          lf_way_d   = linefill_way;
          lf_index_d = linefill_index;
          lf_mshr_d  = linefill_mshr_idx;
          // Count only grants that actually made a read wait.
          if (dataram_rd_vld && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + STARVE_ONE;
          end
        end
      end
      S_RD_BURST: begin
        beat_d = beat_q + BEAT_ONE;
        if (beat_q == BEAT_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_WR_BURST: begin
        if (linefill_beat_vld) begin
          beat_d = beat_q + BEAT_ONE;
          if (beat_q == BEAT_LAST) begin
            state_d    = S_IDLE;
            done_d     = 1'b1;
            done_idx_d = lf_mshr_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; everything reads as zero while reset is held.
  always_comb begin
    dataram_rd_rdy      = rst_n && (state_q == S_IDLE) && rd_win;
    linefill_beat_rdy   = rst_n && (((state_q == S_IDLE) && lf_win) || (state_q == S_WR_BURST));
    ram_en              = acc_en;
    ram_we              = acc_we;
    ram_way             = rst_n ? acc_way : 1'b0;
    ram_addr            = rst_n ? acc_addr : '0;
    ram_wdata           = rst_n ? acc_wdata : '0;
    upstream_txdat_en   = rst_n && tx_en_q;
    upstream_txdat_last = rst_n && tx_last_q;
    upstream_txdat_data = rst_n ? ram_rdata : '0;
    linefill_done       = rst_n && done_q;
    linefill_done_idx   = rst_n ? done_idx_q : '0;
  end

endmodule

// File: tb/tb_icache_dataram_arb.sv
// tb/tb_icache_dataram_arb.sv - scoreboard testbench for icache_dataram_arb
module tb_icache_dataram_arb;

  localparam int INDEX_W  = 7;
  localparam int BEAT_NUM = 4;
  localparam int DW       = 256;
  localparam int MW       = 3;
  localparam int ADDR_W   = 9;

  typedef struct {
    logic              we;
    logic              way;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     wdata;
    int                cyc;
  } ram_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } tx_exp_t;

  typedef struct {
    logic [MW-1:0] idx;
    int            cyc;
  } done_exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                dataram_rd_vld = 1'b0;
  logic                dataram_rd_rdy;
  logic                dataram_rd_way = 1'b0;
  logic [INDEX_W-1:0]  dataram_rd_index = '0;
  logic                linefill_beat_vld = 1'b0;
  logic                linefill_beat_rdy;
  logic                linefill_way = 1'b0;
  logic [INDEX_W-1:0]  linefill_index = '0;
  logic [MW-1:0]       linefill_mshr_idx = '0;
  logic [DW-1:0]       linefill_beat_data = '0;
  logic                ram_en, ram_we, ram_way;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DW-1:0]       ram_wdata;
  logic [DW-1:0]       ram_rdata = '0;
  logic                upstream_txdat_en, upstream_txdat_last;
  logic [DW-1:0]       upstream_txdat_data;
  logic                linefill_done;
  logic [MW-1:0]       linefill_done_idx;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  bit mon_on = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;

  ram_exp_t  exp_ram[$];
  tx_exp_t   exp_tx[$];
  done_exp_t exp_done[$];

  icache_dataram_arb dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dataram_rd_vld      (dataram_rd_vld),
    .dataram_rd_rdy      (dataram_rd_rdy),
    .dataram_rd_way      (dataram_rd_way),
    .dataram_rd_index    (dataram_rd_index),
    .linefill_beat_vld   (linefill_beat_vld),
    .linefill_beat_rdy   (linefill_beat_rdy),
    .linefill_way        (linefill_way),
    .linefill_index      (linefill_index),
    .linefill_mshr_idx   (linefill_mshr_idx),
    .linefill_beat_data  (linefill_beat_data),
    .ram_en              (ram_en),
    .ram_we              (ram_we),
    .ram_way             (ram_way),
    .ram_addr            (ram_addr),
    .ram_wdata           (ram_wdata),
    .ram_rdata           (ram_rdata),
    .upstream_txdat_en   (upstream_txdat_en),
    .upstream_txdat_last (upstream_txdat_last),
    .upstream_txdat_data (upstream_txdat_data),
    .linefill_done       (linefill_done),
    .linefill_done_idx   (linefill_done_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rd_pat(input logic w, input logic [ADDR_W-1:0] a);
    logic [DW-1:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = {16'hC0DE, 6'(k), w, a};
    return r;
  endfunction

  // RAM model: read data one cycle after the read strobe.
  always @(posedge clk) begin
    if (ram_en && !ram_we) ram_rdata <= rd_pat(ram_way, ram_addr);
  end

  // Monitor: pops expectations as the DUT produces output.
  always @(negedge clk) begin
    ram_exp_t  e;
    tx_exp_t   t;
    done_exp_t d;
    #1;
    if (mon_on) begin
      if (ram_en) begin
        tests_run++;
        if (exp_ram.size() == 0) begin
          tests_failed++;
          $display("FAIL ram_unexpected cyc=%0d we=%0b addr=%0d", cyc, ram_we, ram_addr);
        end else begin
          e = exp_ram.pop_front();
          if (ram_we !== e.we || ram_way !== e.way || ram_addr !== e.addr ||
              (e.we && ram_wdata !== e.wdata) || cyc != e.cyc) begin
            tests_failed++;
            $display("FAIL ram_access got we=%0b way=%0b addr=%0d cyc=%0d, expected we=%0b way=%0b addr=%0d cyc=%0d",
                     ram_we, ram_way, ram_addr, cyc, e.we, e.way, e.addr, e.cyc);
          end
        end
        last_addr = ram_addr;
      end else begin
        if (!rst_n) last_addr = '0;
        tests_run++;
        if (ram_we !== 1'b0 || ram_addr !== last_addr) begin
          tests_failed++;
          $display("FAIL ram_idle_hold cyc=%0d got we=%0b addr=%0d, expected we=0 addr=%0d",
                   cyc, ram_we, ram_addr, last_addr);
        end
      end
      if (upstream_txdat_en) begin
        tests_run++;
        if (exp_tx.size() == 0) begin
          tests_failed++;
          $display("FAIL txdat_unexpected cyc=%0d last=%0b", cyc, upstream_txdat_last);
        end else begin
          t = exp_tx.pop_front();
          if (upstream_txdat_data !== t.data || upstream_txdat_last !== t.last || cyc != t.cyc) begin
            tests_failed++;
            $display("FAIL txdat got last=%0b cyc=%0d data=%h, expected last=%0b cyc=%0d data=%h",
                     upstream_txdat_last, cyc, upstream_txdat_data[31:0], t.last, t.cyc, t.data[31:0]);
          end
        end
      end else if (upstream_txdat_last !== 1'b0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL txdat_last_without_en cyc=%0d got 1 expected 0", cyc);
      end
      if (linefill_done) begin
        tests_run++;
        if (exp_done.size() == 0) begin
          tests_failed++;
          $display("FAIL done_unexpected cyc=%0d idx=%0d", cyc, linefill_done_idx);
        end else begin
          d = exp_done.pop_front();
          if (linefill_done_idx !== d.idx || cyc != d.cyc) begin
            tests_failed++;
            $display("FAIL linefill_done got idx=%0d cyc=%0d, expected idx=%0d cyc=%0d",
                     linefill_done_idx, cyc, d.idx, d.cyc);
          end
        end
      end
    end
  end

  // Read request; returns one cycle after grant with vld dropped and
  // way/index scrambled. nbeats < BEAT_NUM models a burst cut by reset.
  task automatic rd_req(input logic way, input logic [INDEX_W-1:0] idx, input int nbeats, output int gcyc);
    int n;
    int ntx;
    ram_exp_t e;
    tx_exp_t  t;
    dataram_rd_vld   = 1'b1;
    dataram_rd_way   = way;
    dataram_rd_index = idx;
    n = 0;
    do begin @(negedge clk); n++; end while (!dataram_rd_rdy && n < 200);
    gcyc = cyc;
    tests_run++;
    if (!dataram_rd_rdy) begin
      tests_failed++;
      $display("FAIL rd_grant_timeout got rdy=0 expected 1");
      gcyc = -1;
    end else begin
      ntx = (nbeats == BEAT_NUM) ? nbeats : nbeats - 1;
      for (int k = 0; k < nbeats; k++) begin
        e.we = 1'b0; e.way = way; e.addr = {idx, 2'(k)}; e.wdata = '0; e.cyc = gcyc + k;
        exp_ram.push_back(e);
      end
      for (int k = 0; k < ntx; k++) begin
        t.data = rd_pat(way, {idx, 2'(k)}); t.last = (k == BEAT_NUM - 1); t.cyc = gcyc + 1 + k;
        exp_tx.push_back(t);
      end
    end
    @(posedge clk); #1;
    dataram_rd_vld   = 1'b0;
    dataram_rd_way   = ~way;
    dataram_rd_index = ~idx;
  endtask

  // Linefill of nbeats beats; target inputs are scrambled after beat 0.
  task automatic lf_burst(input logic way, input logic [INDEX_W-1:0] idx, input logic [MW-1:0] mshr,
                          input int gap_after, input int nbeats, input bit keep_vld, output int gcyc);
    int n;
    logic [31:0] r;
    ram_exp_t  e;
    done_exp_t d;
    gcyc = -1;
    for (int b = 0; b < nbeats; b++) begin
      r = $urandom();
      linefill_beat_vld  = 1'b1;
      linefill_beat_data = {8{r}};
      linefill_way       = (b == 0) ? way  : ~way;
      linefill_index     = (b == 0) ? idx  : ~idx;
      linefill_mshr_idx  = (b == 0) ? mshr : ~mshr;
      n = 0;
      do begin @(negedge clk); n++; end while (!linefill_beat_rdy && n < 200);
      tests_run++;
      if (!linefill_beat_rdy) begin
        tests_failed++;
        $display("FAIL lf_beat_timeout beat=%0d got rdy=0 expected 1", b);
        linefill_beat_vld = 1'b0;
        return;
      end
      if (b == 0) gcyc = cyc;
      e.we = 1'b1; e.way = way; e.addr = {idx, 2'(b)}; e.wdata = {8{r}}; e.cyc = cyc;
      exp_ram.push_back(e);
      if (b == BEAT_NUM - 1) begin
        d.idx = mshr; d.cyc = cyc + 1;
        exp_done.push_back(d);
      end
      @(posedge clk); #1;
      if (b == gap_after) begin
        linefill_beat_vld  = 1'b0;
        linefill_beat_data = ~{8{r}};
        repeat (2) @(posedge clk);
        #1;
      end
    end
    if (!keep_vld) linefill_beat_vld = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    dataram_rd_vld = 1'b1;
    linefill_beat_vld = 1'b1;
    @(posedge clk);
    mon_on = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    tests_run++;
    if ({ram_en, ram_we, dataram_rd_rdy, linefill_beat_rdy, upstream_txdat_en,
         upstream_txdat_last, linefill_done} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_strobes got %b expected 0000000", {ram_en, ram_we, dataram_rd_rdy,
               linefill_beat_rdy, upstream_txdat_en, upstream_txdat_last, linefill_done});
    end
    tests_run++;
    if (ram_addr !== '0 || ram_way !== 1'b0 || linefill_done_idx !== '0) begin
      tests_failed++;
      $display("FAIL reset_fields got addr=%0d way=%0b idx=%0d expected 0", ram_addr, ram_way, linefill_done_idx);
    end
    tests_run++;
    if (upstream_txdat_data !== '0 || ram_wdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_data got nonzero expected 0");
    end
    @(posedge clk); #1;
    dataram_rd_vld = 1'b0;
    linefill_beat_vld = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_only;
    int g;
    rd_req(1'b1, 7'd5, BEAT_NUM, g);
    repeat (8) @(posedge clk);
    #1;
    tests_run++;
    if (exp_ram.size() != 0 || exp_tx.size() != 0) begin
      tests_failed++;
      $display("FAIL read_only_drain got ram=%0d tx=%0d pending expected 0", exp_ram.size(), exp_tx.size());
    end
  endtask

  task automatic test_linefill_contig;
    int g;
    lf_burst(1'b0, 7'd3, 3'd2, -1, BEAT_NUM, 1'b0, g);
    repeat (6) @(posedge clk);
    #1;
    tests_run++;
    if (exp_ram.size() != 0 || exp_done.size() != 0) begin
      tests_failed++;
      $display("FAIL lf_contig_drain got ram=%0d done=%0d pending expected 0", exp_ram.size(), exp_done.size());
    end
  endtask

  task automatic test_linefill_gap;
    int g;
    lf_burst(1'b1, 7'd9, 3'd5, 1, BEAT_NUM, 1'b0, g);
    repeat (6) @(posedge clk);
    #1;
    tests_run++;
    if (exp_ram.size() != 0 || exp_done.size() != 0) begin
      tests_failed++;
      $display("FAIL lf_gap_drain got ram=%0d done=%0d pending expected 0", exp_ram.size(), exp_done.size());
    end
  endtask

  task automatic test_starve;
    int c0;
    int lg[9];
    int rg0, rg1;
    int lf_off[9] = '{0, 4, 8, 12, 20, 24, 28, 32, 40};
    c0 = cyc;
    fork
      begin
        for (int i = 0; i < 9; i++)
          lf_burst(1'(i), 7'(10 + i), 3'(i), -1, BEAT_NUM, (i < 8), lg[i]);
      end
      begin
        rd_req(1'b0, 7'd40, BEAT_NUM, rg0);
        rd_req(1'b1, 7'd41, BEAT_NUM, rg1);
      end
    join
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (lg[i] != c0 + lf_off[i]) begin
        tests_failed++;
        $display("FAIL starve_lf_grant%0d got cyc=%0d expected %0d", i, lg[i], c0 + lf_off[i]);
      end
    end
    tests_run++;
    if (rg0 != c0 + 16 || rg1 != c0 + 36) begin
      tests_failed++;
      $display("FAIL starve_rd_grant got %0d,%0d expected %0d,%0d", rg0, rg1, c0 + 16, c0 + 36);
    end
    repeat (6) @(posedge clk);
    #1;
    tests_run++;
    if (exp_ram.size() != 0 || exp_tx.size() != 0 || exp_done.size() != 0) begin
      tests_failed++;
      $display("FAIL starve_drain got ram=%0d tx=%0d done=%0d pending expected 0",
               exp_ram.size(), exp_tx.size(), exp_done.size());
    end
  endtask

  task automatic test_reset_midburst;
    int g;
    lf_burst(1'b0, 7'd6, 3'd4, -1, 3, 1'b0, g);
    rst_n = 1'b0;
    @(negedge clk); #2;
    tests_run++;
    if ({dataram_rd_rdy, linefill_beat_rdy, ram_en, linefill_done} !== 4'b0) begin
      tests_failed++;
      $display("FAIL midreset_outputs got %b expected 0000",
               {dataram_rd_rdy, linefill_beat_rdy, ram_en, linefill_done});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_req(1'b0, 7'd8, 2, g);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_req(1'b1, 7'd2, BEAT_NUM, g);
    repeat (8) @(posedge clk);
    #1;
    tests_run++;
    if (exp_ram.size() != 0 || exp_tx.size() != 0 || exp_done.size() != 0) begin
      tests_failed++;
      $display("FAIL midreset_drain got ram=%0d tx=%0d done=%0d pending expected 0",
               exp_ram.size(), exp_tx.size(), exp_done.size());
    end
  endtask

  initial begin
    test_reset();
    test_read_only();
    test_linefill_contig();
    test_linefill_gap();
    test_starve();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired expected completion");
    $fatal(1);
  end

endmodule
